// File: rtl/mix_tx_arbiter_pkg.sv
// Shared state encoding, character constants and id width for the MIX transmit arbiter.
package mix_tx_arbiter_pkg;

  localparam int DEFAULT_DW = 7;
  localparam int GID_W      = 3;

  localparam logic [6:0] CHAR_CR = 7'd13;
  localparam logic [6:0] CHAR_LF = 7'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WSTART,
    ST_WDONE
  } tx_state_e;

  function automatic logic is_eol(input logic [6:0] ch);
    return (ch == CHAR_CR) || (ch == CHAR_LF);
  endfunction

endpackage

// File: rtl/mix_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after ptr, wrapping once.
module mix_tx_arbiter_rr_pick
  import mix_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [GID_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [GID_W-1:0] winner_o
);

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!valid_o && req_i[i] && (i == ((int'(ptr_i) + k) % NREQ))) begin
          valid_o  = 1'b1;
          winner_o = GID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mix_tx_arbiter.sv
// Round-robin sharing of the UartTX transmitter between NREQ character sources.
// Optional `MIX_TX_LINE_LOCK_EN keeps a granted source until it sends CR or LF.
module mix_tx_arbiter
  import mix_tx_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int DW       = DEFAULT_DW,
  parameter int START_TO = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]    ack,
  output logic [GID_W-1:0]   grant_id,
  output logic               tx_load,
  output logic [DW-1:0]      tx_data,
  input  logic               tx_busy
);

  localparam int CNT_W = (START_TO > 1) ? $clog2(START_TO) : 1;

  tx_state_e        state_q, state_d;
  logic [GID_W-1:0] ptr_q, ptr_d;
  logic [GID_W-1:0] grant_q, grant_d;
  logic [DW-1:0]    data_q, data_d;
  logic             load_q, load_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  pick_req;
  logic             pick_valid;
  logic [GID_W-1:0] pick_winner;

`ifdef MIX_TX_LINE_LOCK_EN
  logic             lock_q, lock_d;
  logic [NREQ-1:0]  owner_mask;

  // While a line is open only its owner may win, unless the owner has gone quiet.
  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_mask[i] = (grant_q == GID_W'(i));
    end
    pick_req = req;
    if (lock_q && (|(req & owner_mask))) begin
      pick_req = req & owner_mask;
    end
  end
`else
  always_comb begin
    pick_req = req;
  end
`endif

  mix_tx_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_i    (pick_req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    load_d  = 1'b0;
    ack_d   = '0;
    cnt_d   = cnt_q;
`ifdef MIX_TX_LINE_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef MIX_TX_LINE_LOCK_EN
        if (lock_q && !(|(req & owner_mask))) begin
          lock_d = 1'b0;
        end
`endif
        if (pick_valid) begin
          grant_d = pick_winner;
          load_d  = 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            if (pick_winner == GID_W'(i)) begin
              data_d   = data[i*DW +: DW];
              ack_d[i] = 1'b1;
            end
          end
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ptr_d   = grant_q;
        cnt_d   = '0;
`ifdef MIX_TX_LINE_LOCK_EN
        lock_d  = !is_eol(7'(data_q));
`endif
        state_d = ST_WSTART;
      end
      // A transmitter that never raises busy must not hang the arbiter.
      ST_WSTART: begin
        if (tx_busy) begin
          state_d = ST_WDONE;
        end else if (cnt_q == CNT_W'(START_TO - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WDONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      ack_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      load_q  <= load_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MIX_TX_LINE_LOCK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`endif

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign tx_load  = load_q;
  assign tx_data  = data_q;

endmodule

// File: tb/tb_mix_tx_arbiter.sv
// Scoreboard bench for mix_tx_arbiter: requester agents, UartTX busy model, round-robin reference.
// Honours `MIX_TX_LINE_LOCK_EN in the reference model when the design is built with it.
module tb_mix_tx_arbiter;

  localparam int NREQ     = 3;
  localparam int DW       = 7;
  localparam int START_TO = 4;

  logic               clk     = 1'b0;
  logic               reset   = 1'b0;
  logic [NREQ-1:0]    req     = '0;
  logic [NREQ*DW-1:0] data    = '0;
  logic               tx_busy = 1'b0;
  logic [NREQ-1:0]    ack;
  logic [2:0]         grant_id;
  logic               tx_load;
  logic [DW-1:0]      tx_data;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] srcQ [NREQ][$];
  logic [DW-1:0] expQ [NREQ][$];

  int  mPtr   = 0;
  bit  mLock  = 0;
  int  mOwner = 0;

  bit  busyMode = 1;
  int  frameLen = 5;
  int  fCnt     = 0;

  int  cycle         = 0;
  int  loadCount     = 0;
  int  lastLoadCycle = 0;
  bit  havePrev      = 0;
  int  expGap        = 0;
  logic [NREQ-1:0] reqHist = '0;
  logic busyPrev = 1'b0;

  mix_tx_arbiter #(
    .NREQ     (NREQ),
    .DW       (DW),
    .START_TO (START_TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .grant_id (grant_id),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic alignDrive();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int r, input logic [DW-1:0] ch);
    srcQ[r].push_back(ch);
    expQ[r].push_back(ch);
  endtask

  // UartTX stand-in: busy rises after the load edge and stays high frameLen clocks; not reset.
  always @(posedge clk) begin
    reqHist <= req;
    if (busyMode && tx_load && !tx_busy) begin
      tx_busy <= 1'b1;
      fCnt    <= frameLen;
    end else if (tx_busy) begin
      if (fCnt <= 1) tx_busy <= 1'b0;
      else           fCnt    <= fCnt - 1;
    end
  end

  // Monitor/scoreboard, then requester agents reacting to the ack just observed.
  always @(negedge clk) begin
    int w;
    int idx;
    logic [DW-1:0] ch;
    cycle++;
    if (reset) begin
      if (tx_load) begin
        w = -1;
`ifdef MIX_TX_LINE_LOCK_EN
        if (mLock && reqHist[mOwner]) w = mOwner;
`endif
        for (int k = 1; k <= NREQ; k++) begin
          idx = (mPtr + k) % NREQ;
          if (w < 0 && reqHist[idx]) w = idx;
        end
        if (w < 0) begin
          checkOutput("load_without_request", int'(tx_load), 0);
        end else begin
          checkOutput("grant_id", int'(grant_id), w);
          checkOutput("ack_onehot", int'(ack), 1 << w);
          checkOutput("char_expected", int'(expQ[w].size() > 0), 1);
          if (expQ[w].size() > 0) begin
            ch = expQ[w].pop_front();
            checkOutput("tx_data", int'(tx_data), int'(ch));
            mLock  = !((ch == 7'd13) || (ch == 7'd10));
            mOwner = w;
          end
          mPtr = w;
        end
        checkOutput("busy_at_load", int'({busyPrev, tx_busy}), 0);
        if (expGap > 0 && havePrev) checkOutput("load_gap", cycle - lastLoadCycle, expGap);
        havePrev      = 1;
        lastLoadCycle = cycle;
        loadCount++;
      end else begin
        checkOutput("ack_without_load", int'(ack), 0);
      end
    end
    busyPrev = tx_busy;
    for (int i = 0; i < NREQ; i++) begin
      if (reset && ack[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
      req[i] = (srcQ[i].size() > 0);
      data[i*DW +: DW] = (srcQ[i].size() > 0) ? srcQ[i][0] : '0;
    end
  end

  task automatic waitDrain(input int budget);
    int quiet;
    int left;
    quiet = 0;
    for (int c = 0; c < budget && quiet < START_TO + 6; c++) begin
      @(negedge clk);
      left = 0;
      for (int i = 0; i < NREQ; i++) left += srcQ[i].size() + expQ[i].size();
      if (left == 0 && !tx_busy) quiet++;
      else quiet = 0;
    end
    left = 0;
    for (int i = 0; i < NREQ; i++) left += expQ[i].size();
    checkOutput("drain_pending_chars", left, 0);
    checkOutput("drain_quiet", int'(quiet >= START_TO + 6), 1);
    // Owner's request has been low in IDLE, so any open line is released.
    mLock = 0;
  endtask

  task automatic waitBusy(input logic level, input string name);
    int c;
    c = 0;
    while (tx_busy !== level && c < 50) begin
      @(negedge clk);
      c++;
    end
    checkOutput(name, int'(tx_busy), int'(level));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int len;
    int r;
    logic [DW-1:0] ch;

    $display("[TB] reset values");
    #12;
    checkOutput("rst_ack", int'(ack), 0);
    checkOutput("rst_tx_load", int'(tx_load), 0);
    checkOutput("rst_tx_data", int'(tx_data), 0);
    checkOutput("rst_grant_id", int'(grant_id), 0);
    @(negedge clk); #1 reset = 1'b1;

    $display("[TB] single requester, load latency");
    busyMode = 1; frameLen = 6;
    alignDrive();
    applyStimulus(0, 7'd65);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t1_load_latency", int'(tx_load), 1);
    checkOutput("t1_tx_data", int'(tx_data), 65);
    checkOutput("t1_ack", int'(ack), 1);
    waitDrain(300);

    $display("[TB] reset during frame");
    frameLen = 12;
    alignDrive();
    applyStimulus(0, 7'd88);
    waitBusy(1'b1, "t3_busy_rose");
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("t3_ack", int'(ack), 0);
    checkOutput("t3_tx_load", int'(tx_load), 0);
    checkOutput("t3_tx_data", int'(tx_data), 0);
    checkOutput("t3_grant_id", int'(grant_id), 0);
    mPtr = 0; mLock = 0; havePrev = 0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    waitBusy(1'b0, "t3_busy_fell");
    alignDrive();
    applyStimulus(1, 7'd70);
    waitDrain(300);

    $display("[TB] two requesters held, frame spacing");
    frameLen = 5; expGap = frameLen + 3; havePrev = 0;
    alignDrive();
    applyStimulus(0, 7'd65); applyStimulus(0, 7'd65);
    applyStimulus(1, 7'd66); applyStimulus(1, 7'd66);
    waitDrain(400);
    expGap = 0;

    $display("[TB] withdrawn request while busy");
    frameLen = 10;
    base = loadCount;
    alignDrive();
    applyStimulus(0, 7'd72);
    waitBusy(1'b1, "t6_busy_rose");
    alignDrive();
    srcQ[2].push_back(7'd90);
    repeat (3) @(negedge clk);
    alignDrive();
    srcQ[2].delete();
    waitDrain(300);
    checkOutput("t6_load_count", loadCount - base, 1);

    $display("[TB] busy never rises, timeout");
    busyMode = 0; expGap = START_TO + 2; havePrev = 0;
    alignDrive();
    applyStimulus(0, 7'd49); applyStimulus(0, 7'd50);
    waitDrain(300);
    expGap = 0; busyMode = 1;

    $display("[TB] line ending characters");
    frameLen = 4;
    alignDrive();
    applyStimulus(0, 7'd65); applyStimulus(0, 7'd66); applyStimulus(0, 7'd13);
    applyStimulus(1, 7'd67);
    waitDrain(400);

    $display("[TB] randomized traffic");
    for (int phase = 0; phase < 4; phase++) begin
      busyMode = ($urandom_range(0, 3) != 0);
      frameLen = $urandom_range(1, 8);
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 8)) @(negedge clk);
        alignDrive();
        r   = $urandom_range(0, NREQ - 1);
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) begin
          if (j == len - 1) ch = ($urandom_range(0, 1) != 0) ? 7'd13 : 7'd10;
          else              ch = 7'(65 + $urandom_range(0, 25));
          applyStimulus(r, ch);
        end
      end
      waitDrain(5000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
